// File: rtl/riscv_instr_port_arbiter_pkg.sv
// Shared types and limits for the instruction-port arbiter slice.
package riscv_instr_arb_pkg;

  localparam int NUM_REQ_MAX     = 8;
  localparam int OUTSTANDING_MAX = 2;

  typedef logic [2:0] owner_id_t;

  function automatic owner_id_t next_owner(owner_id_t cur, int num_req);
    return (int'(cur) == num_req - 1) ? owner_id_t'(0) : cur + owner_id_t'(1);
  endfunction

endpackage

// File: rtl/riscv_instr_port_arbiter_if.sv
// Instruction-memory bus: req/gnt address phase plus rvalid data phase with PMP fault.
interface riscv_instr_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              instr_req_o;
  logic [ADDR_W-1:0] instr_addr_o;
  logic              instr_gnt_i;
  logic [DATA_W-1:0] instr_rdata_i;
  logic              instr_rvalid_i;
  logic              instr_err_pmp_i;

  modport master (
    output instr_req_o, instr_addr_o,
    input  instr_gnt_i, instr_rdata_i, instr_rvalid_i, instr_err_pmp_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o,
    output instr_gnt_i, instr_rdata_i, instr_rvalid_i, instr_err_pmp_i
  );
endinterface

// File: rtl/riscv_instr_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module riscv_rr_arbiter
  import riscv_instr_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  owner_id_t          ptr,
  output owner_id_t          sel,
  output logic               valid
);

  int idx;

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!valid && (j == idx) && req[j]) begin
          valid = 1'b1;
          sel   = owner_id_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/riscv_instr_port_arbiter.sv
// Shares one instruction port among NUM_REQ fetch requesters with in-order response routing.
// INSTR_ARB_FIXED_PRIO_EN selects fixed priority (index 0 highest) instead of round-robin.
module riscv_instr_port_arbiter
  import riscv_instr_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             rvalid_o,
  output logic [DATA_W-1:0]              rdata_o,
  output logic [NUM_REQ-1:0]             err_pmp_o,
  riscv_instr_port_arbiter_if.master     mem,
  output logic                           protocol_err_o
);

  logic              lock;
  owner_id_t         lock_sel;
  owner_id_t         arb_ptr;
  owner_id_t         arb_sel;
  logic              arb_valid;
  owner_id_t         sel;
  logic              req_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [ADDR_W-1:0] last_addr;
  logic              issue, accept, fault, resp, wr_idx;
  logic [1:0]        outstanding;
  owner_id_t         owner_fifo [2];

`ifdef INSTR_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  owner_id_t rr_ptr;
  assign arb_ptr = rr_ptr;
`endif

  riscv_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req   (req_i),
    .ptr   (arb_ptr),
    .sel   (arb_sel),
    .valid (arb_valid)
  );

  // A locked requester keeps the port; its address still follows addr_i live.
  always_comb begin
    sel      = lock ? lock_sel : arb_sel;
    req_sel  = 1'b0;
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == owner_id_t'(i)) begin
        req_sel  = req_i[i];
        addr_sel = addr_i[i];
      end
    end
    issue  = req_sel & ((outstanding < 2'(OUTSTANDING_MAX)) | mem.instr_rvalid_i);
    accept = issue & mem.instr_gnt_i & ~mem.instr_err_pmp_i;
    fault  = issue & mem.instr_err_pmp_i;
    resp   = mem.instr_rvalid_i & (outstanding != 2'd0);
    wr_idx = (outstanding == 2'd2) | ((outstanding == 2'd1) & ~resp);
    gnt_o     = '0;
    err_pmp_o = '0;
    rvalid_o  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == owner_id_t'(i)) begin
        gnt_o[i]     = accept;
        err_pmp_o[i] = fault;
      end
      if (owner_fifo[0] == owner_id_t'(i)) rvalid_o[i] = resp;
    end
  end

  assign mem.instr_req_o  = issue;
  assign mem.instr_addr_o = issue ? addr_sel : last_addr;
  assign rdata_o          = mem.instr_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock           <= 1'b0;
      lock_sel       <= '0;
      outstanding    <= '0;
      protocol_err_o <= 1'b0;
`ifndef INSTR_ARB_FIXED_PRIO_EN
      rr_ptr         <= '0;
`endif
    end else begin
      if (accept || fault) begin
        lock <= 1'b0;
`ifndef INSTR_ARB_FIXED_PRIO_EN
        rr_ptr <= next_owner(sel, NUM_REQ);
`endif
      end else if (issue) begin
        lock     <= 1'b1;
        lock_sel <= sel;
      end else if (lock && !req_sel) begin
        lock <= 1'b0;
      end
      unique case ({accept, resp})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
      if (mem.instr_rvalid_i && (outstanding == 2'd0)) protocol_err_o <= 1'b1;
    end
  end

  // Owner FIFO and held address are data only; outstanding qualifies their use.
  always_ff @(posedge clk) begin
    if (issue) last_addr <= addr_sel;
    if (resp) owner_fifo[0] <= owner_fifo[1];
    if (accept) owner_fifo[wr_idx] <= sel;
  end

endmodule

// File: doc/riscv_instr_port_arbiter.md
# riscv_instr_port_arbiter

Shares one instruction-memory port between NUM_REQ fetch requesters, one `riscv_prefetch_buffer` per hart context. Requests use a req/gnt address phase and an rvalid data phase. The block locks the selected requester until its address phase completes. It tracks up to two outstanding transactions in order and routes each response and PMP error back to the requester that issued it. It sits between the per-hart prefetch buffers and the PMP checker / instruction cache.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, legal range 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: fetch data width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester address-phase request.
- addr_i  in  NUM_REQ×ADDR_W  per-requester fetch address.
- gnt_o  out  NUM_REQ  per-requester grant.
- rvalid_o  out  NUM_REQ  per-requester response valid.
- rdata_o  out  DATA_W  response data, broadcast to all requesters.
- err_pmp_o  out  NUM_REQ  per-requester PMP fault.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  ADDR_W  memory address.
- instr_gnt_i  in  1  memory grant.
- instr_rdata_i  in  DATA_W  memory data.
- instr_rvalid_i  in  1  memory response valid.
- instr_err_pmp_i  in  1  PMP fault for the current address.
- protocol_err_o  out  1  sticky flag: unexpected rvalid.

## Operation
- Selection: when not locked, a round-robin picker chooses one asserted req_i.
  - Search starts at rr_ptr.
  - sel is the chosen requester's index.
- Lock: if instr_req_o=1 and instr_gnt_i=0, the block sets lock=1 and stores sel.
  - While locked, sel is frozen; other requesters are ignored.
  - addr_i[sel] is still forwarded live, so a branch may change the address while waiting for grant.
  - If req_i[sel] drops while locked, lock clears and no transaction is counted.
- Issue gating: instr_req_o = req_i[sel] & (outstanding<2 | instr_rvalid_i).
  - instr_addr_o = addr_i[sel].
  - When no request is issued, instr_addr_o holds the last issued address.
- Accept (instr_req_o & instr_gnt_i & ~instr_err_pmp_i):
  - gnt_o[sel]=1.
  - Push sel into the 2-entry owner FIFO and increment outstanding.
  - Clear lock and set rr_ptr = sel+1 modulo NUM_REQ.
- PMP fault (instr_req_o & instr_err_pmp_i):
  - err_pmp_o[sel]=1; gnt_o stays 0.
  - No FIFO push and no outstanding increment.
  - Clear lock and advance rr_ptr as on accept.
- Response (instr_rvalid_i with outstanding>0):
  - rvalid_o[FIFO head]=1.
  - Pop the FIFO and decrement outstanding.
- Unexpected response (instr_rvalid_i with outstanding=0):
  - Ignored: all rvalid_o stay 0.
  - protocol_err_o set to 1; it clears only on rst.
- Simultaneous accept and response: push and pop in the same cycle; outstanding is unchanged.
- Requesters are never reordered; responses return in issue order.

## Timing
- All grant, response and error outputs are combinational from their inputs; zero added latency on either phase.
- Paths:
  - instr_gnt_i → gnt_o
  - instr_rvalid_i → rvalid_o
  - instr_err_pmp_i → err_pmp_o
- A requester may issue its next request in the same cycle its rvalid arrives; the arbiter must not introduce a bubble.
- Reset values:
  - lock=0, rr_ptr=0, outstanding=0, owner FIFO empty, protocol_err_o=0.
  - With req_i=0: all gnt_o, rvalid_o and err_pmp_o are 0, and instr_req_o=0.
- Reset asserted mid-transaction drops all tracking; rvalids arriving after reset count as unexpected.
- outstanding width is 2 bits and saturates at 2; the issue gate guarantees it never exceeds 2.

## Configuration
- Macro: INSTR_ARB_FIXED_PRIO_EN.
- Defined: selection is fixed priority, index 0 highest; rr_ptr is removed.
- Undefined (default): round-robin selection as described in Operation.
- Lock, FIFO and error behaviour are identical in both builds.

## Structure
- Package riscv_instr_arb_pkg holds:
  - NUM_REQ_MAX=8.
  - typedef owner_id_t, logic[2:0].
  - OUTSTANDING_MAX=2.
- Sub-module riscv_rr_arbiter: combinational round-robin picker with inputs req vector and ptr, outputs sel index and valid.
- The owner FIFO and lock logic stay in the top module.

## Test plan
- Contention: req_i=2'b11 at reset, instr_gnt_i=1 every cycle. Requires grants alternate 0,1,0,1 and rvalid_o follows the same order one cycle later.
- Held grant: req_i[1]=1 with instr_gnt_i=0 for 3 cycles, then req_i[0] is raised. Requires instr_addr_o=addr_i[1] throughout and the first grant goes to requester 1. When addr_i[1] changes 0x100→0x200 mid-wait, the issued address is 0x200.
- Back-to-back: gnt and rvalid every cycle for requester 0. Requires outstanding steady at 1 and no idle cycles. Holding rvalid low for 2 accepts blocks instr_req_o until an rvalid arrives.
- PMP fault: instr_err_pmp_i=1 on requester 1's request. Requires err_pmp_o[1]=1, gnt_o=0 and outstanding unchanged; requester 0 is served next cycle.
- Protocol error: rvalid with outstanding=0 sets protocol_err_o=1 and all rvalid_o stay 0; rst clears it. Rebuild with INSTR_ARB_FIXED_PRIO_EN: req_i=2'b11 every cycle always grants 0.
